// File: rtl/input_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : input_port_arbiter_pkg
//  Purpose  : Shared types and round-robin pick helper for input_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package input_port_arbiter_pkg;

    localparam int NUM_PORTS  = 8;
    localparam int PORT_IDX_W = 3;

    localparam int IO_QUEUE_STAGE_NUM = 8'hFF;
    localparam int IOQ_SRC_PORT_POS   = 16;

    typedef struct packed {
        logic                  valid;
        logic [PORT_IDX_W-1:0] idx;
    } rr_pick_t;

    // First requesting port at or after ptr, wrapping; descending loop so the
    // smallest offset from ptr is the last (winning) assignment.
    function automatic rr_pick_t rr_pick(input logic [NUM_PORTS-1:0] req,
                                         input logic [PORT_IDX_W-1:0] ptr);
        rr_pick_t              res;
        logic [PORT_IDX_W-1:0] idx;
        res = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = ptr + PORT_IDX_W'(i);
            if (req[idx]) begin
                res.valid = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fallthrough_small_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fallthrough_small_fifo
//  Purpose  : Small first-word-fall-through FIFO with a one-entry nearly-full
//             margin; head word is visible on dout whenever not empty.
//  Revision : 1.0  initial release
// ============================================================================
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] C_NF_THRESH = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
    logic [MAX_DEPTH_BITS:0]   r_count;
    logic                      w_do_rd;

    assign w_do_rd     = rd_en && !empty;
    assign empty       = (r_count == '0);
    assign nearly_full = (r_count >= C_NF_THRESH);
    assign dout        = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({wr_en, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/input_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : input_port_arbiter
//  Purpose  : Merges eight buffered input packet streams into one, granting
//             whole packets round-robin. Optional build macro
//             INPUT_ARB_SRC_PORT_STAMP_EN stamps the grant index into the
//             I/O-queue module header.
//  Revision : 1.0  initial release
// ============================================================================
module input_port_arbiter
    import input_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH         = 64,
    parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int NUM_INPUT_QUEUES   = 8,
    parameter int IN_FIFO_DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data_0,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_0,
    input  logic                  in_wr_0,
    output logic                  in_rdy_0,
    input  logic [DATA_WIDTH-1:0] in_data_1,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_1,
    input  logic                  in_wr_1,
    output logic                  in_rdy_1,
    input  logic [DATA_WIDTH-1:0] in_data_2,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_2,
    input  logic                  in_wr_2,
    output logic                  in_rdy_2,
    input  logic [DATA_WIDTH-1:0] in_data_3,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_3,
    input  logic                  in_wr_3,
    output logic                  in_rdy_3,
    input  logic [DATA_WIDTH-1:0] in_data_4,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_4,
    input  logic                  in_wr_4,
    output logic                  in_rdy_4,
    input  logic [DATA_WIDTH-1:0] in_data_5,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_5,
    input  logic                  in_wr_5,
    output logic                  in_rdy_5,
    input  logic [DATA_WIDTH-1:0] in_data_6,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_6,
    input  logic                  in_wr_6,
    output logic                  in_rdy_6,
    input  logic [DATA_WIDTH-1:0] in_data_7,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_7,
    input  logic                  in_wr_7,
    output logic                  in_rdy_7,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy
);

    localparam int FW = CTRL_WIDTH + DATA_WIDTH;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HDR     = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;

    logic [FW-1:0]               w_din  [NUM_INPUT_QUEUES];
    logic [FW-1:0]               w_dout [NUM_INPUT_QUEUES];
    logic [NUM_INPUT_QUEUES-1:0] w_wr;
    logic [NUM_INPUT_QUEUES-1:0] w_rd;
    logic [NUM_INPUT_QUEUES-1:0] w_nf;
    logic [NUM_INPUT_QUEUES-1:0] w_empty;

    logic [1:0]             r_state;
    logic [PORT_IDX_W-1:0]  r_grant;
    logic [PORT_IDX_W-1:0]  r_rr_ptr;
    logic                   r_out_wr;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic [CTRL_WIDTH-1:0]  r_out_ctrl;

    logic [FW-1:0]          w_head;
    logic [DATA_WIDTH-1:0]  w_head_data;
    logic [CTRL_WIDTH-1:0]  w_head_ctrl;
    logic [DATA_WIDTH-1:0]  w_out_data;
    logic                   w_rd_grant;
    rr_pick_t               w_pick;

    assign w_din[0] = {in_ctrl_0, in_data_0};
    assign w_din[1] = {in_ctrl_1, in_data_1};
    assign w_din[2] = {in_ctrl_2, in_data_2};
    assign w_din[3] = {in_ctrl_3, in_data_3};
    assign w_din[4] = {in_ctrl_4, in_data_4};
    assign w_din[5] = {in_ctrl_5, in_data_5};
    assign w_din[6] = {in_ctrl_6, in_data_6};
    assign w_din[7] = {in_ctrl_7, in_data_7};
    assign w_wr     = {in_wr_7, in_wr_6, in_wr_5, in_wr_4,
                       in_wr_3, in_wr_2, in_wr_1, in_wr_0};

    assign in_rdy_0 = !w_nf[0];
    assign in_rdy_1 = !w_nf[1];
    assign in_rdy_2 = !w_nf[2];
    assign in_rdy_3 = !w_nf[3];
    assign in_rdy_4 = !w_nf[4];
    assign in_rdy_5 = !w_nf[5];
    assign in_rdy_6 = !w_nf[6];
    assign in_rdy_7 = !w_nf[7];

    for (genvar gi = 0; gi < NUM_INPUT_QUEUES; gi++) begin : g_fifo
        fallthrough_small_fifo #(
            .WIDTH          (FW),
            .MAX_DEPTH_BITS (IN_FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .din         (w_din[gi]),
            .wr_en       (w_wr[gi]),
            .rd_en       (w_rd[gi]),
            .dout        (w_dout[gi]),
            .nearly_full (w_nf[gi]),
            .empty       (w_empty[gi])
        );
    end

    assign w_head      = w_dout[r_grant];
    assign w_head_data = w_head[DATA_WIDTH-1:0];
    assign w_head_ctrl = w_head[FW-1:DATA_WIDTH];
    assign w_pick      = rr_pick(~w_empty, r_rr_ptr);

    // out_rdy gates the read combinationally, so a stall costs no extra word.
    assign w_rd_grant  = (r_state != IDLE) && !w_empty[r_grant] && out_rdy;

    always_comb begin
        w_rd = '0;
        if (w_rd_grant) begin
            w_rd[r_grant] = 1'b1;
        end
    end

`ifdef INPUT_ARB_SRC_PORT_STAMP_EN
    always_comb begin
        w_out_data = w_head_data;
        if (r_state == HDR && w_head_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM)) begin
            w_out_data[IOQ_SRC_PORT_POS +: 16] = 16'(r_grant);
        end
    end
`else
    assign w_out_data = w_head_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_out_wr   <= 1'b0;
            r_out_data <= '0;
            r_out_ctrl <= '0;
        end else begin
            r_out_wr <= w_rd_grant;
            if (w_rd_grant) begin
                r_out_data <= w_out_data;
                r_out_ctrl <= w_head_ctrl;
            end
            case (r_state)
                IDLE: begin
                    if (w_pick.valid) begin
                        r_grant <= w_pick.idx;
                        r_state <= HDR;
                    end
                end
                HDR: begin
                    if (w_rd_grant && w_head_ctrl == '0) begin
                        r_state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (w_rd_grant && w_head_ctrl != '0) begin
                        r_rr_ptr <= r_grant + 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_wr   = r_out_wr;
    assign out_data = r_out_data;
    assign out_ctrl = r_out_ctrl;

endmodule
`default_nettype wire

// File: doc/input_port_arbiter.md
# input_port_arbiter

- Merges eight independent input packet streams into the single stream that feeds the user data path.
- Each input has its own small buffer; whole packets are granted round-robin, so an output packet is never interleaved with another.
- Sits at the head of the pipeline. It is the mirror of the output-queue stage, which splits one stream into eight by destination bitmap.

## Interface
- DATA_WIDTH, 64, data word width
- CTRL_WIDTH, DATA_WIDTH/8, ctrl word width
- NUM_INPUT_QUEUES, 8, number of input ports (fixed at 8)
- IN_FIFO_DEPTH_BITS, 3, log2 depth of each input buffer

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- in_data_N  in  DATA_WIDTH  port N data word (N = 0..7)
- in_ctrl_N  in  CTRL_WIDTH  port N ctrl word
- in_wr_N  in  1  port N write strobe
- in_rdy_N  out  1  port N may write; equals !nearly_full of buffer N
- out_data  out  DATA_WIDTH  merged data, registered
- out_ctrl  out  CTRL_WIDTH  merged ctrl, registered
- out_wr  out  1  merged write strobe, registered
- out_rdy  in  1  downstream can accept (nearly-full semantics)

## Operation
- Buffer N is first-word-fall-through: head word is visible while non-empty.
- Packet framing:
  - Leading words with ctrl != 0 are module headers.
  - ctrl == 0 words are payload.
  - The first ctrl != 0 word after payload is the last word.
  - A packet must contain at least one ctrl == 0 word.
- State machine: IDLE, HDR, PAYLOAD.
- IDLE:
  - Scan ports starting at rr_ptr, wrapping 7->0, for the first non-empty buffer.
  - Register grant = that port and go to HDR.
  - If all buffers are empty, stay in IDLE.
- HDR/PAYLOAD, word read rule:
  - Read a word (rd_en[grant]) when buffer[grant] is non-empty and out_rdy = 1.
  - No read otherwise; the word is held.
- HDR: reading a ctrl == 0 word moves to PAYLOAD.
- PAYLOAD: reading a ctrl != 0 word ends the packet:
  - rr_ptr <= grant+1 (mod 8);
  - return to IDLE.
- Only the granted buffer is ever read. Ungranted buffers fill, and their in_rdy deasserts at nearly-full.
- Output register: each read word is loaded into out_data/out_ctrl, with out_wr = 1, in the next cycle. out_wr = 0 otherwise.
- A single active port is re-granted after each IDLE bubble.

## Timing
- Reset values:
  - out_wr = 0, out_data = 0, out_ctrl = 0;
  - state = IDLE, grant = 0, rr_ptr = 0;
  - all buffers empty, so in_rdy_N = 1.
- Reset mid-packet: all buffers are flushed and the partial packet is discarded. Downstream sees no further words from it.
- Latency: in_wr_N at cycle t (buffer empty, state IDLE) gives:
  - IDLE grant decision at t+1;
  - first read at t+2;
  - out_wr at t+3.
- Throughput: one word per cycle within a packet, with a one-cycle IDLE bubble between packets.
- Back-pressure: out_rdy is sampled combinationally for rd_en. At most one word is emitted in the cycle after out_rdy falls; downstream must tolerate this.
- Simultaneous non-empty ports: the lowest index at or after rr_ptr wins.
- A buffer receiving in_wr while being read at full depth is legal because of the nearly-full margin. Writes when full are a protocol violation and are not handled.

## Configuration
- INPUT_ARB_SRC_PORT_STAMP_EN defined:
  - In HDR, the word whose ctrl == `IO_QUEUE_STAGE_NUM is modified on output.
  - Data bits [`IOQ_SRC_PORT_POS+15:`IOQ_SRC_PORT_POS] are replaced by the 16-bit binary grant index.
  - All other bits pass unchanged.
- Undefined: all words pass bit-exact.

## Structure
- Use the shared defines already in the shared defines file (`IO_QUEUE_STAGE_NUM, `IOQ_SRC_PORT_POS); add none.
- Declare the state encodings (IDLE = 0, HDR = 1, PAYLOAD = 2) as localparams in the module.
- Sub-module: fallthrough_small_fifo, instantiated eight times in a generate loop, width CTRL_WIDTH+DATA_WIDTH.

## Test plan
- Reset, then one packet on port 3:
  - stimulus: header ctrl=0xFF data=0x0004_0000_0000_0100, two payload words ctrl=0, last word ctrl=0x01, all sent at t;
  - required: four out_wr words from t+3 with ctrl 0xFF,0x00,0x00,0x01, in order;
  - required: rr_ptr = 4 afterwards.
- Ports 0, 2 and 7 each preloaded with a 3-word packet, out_rdy held 1:
  - required output order is 0, 2, 7, each packet contiguous;
  - required: exactly one idle cycle between packets.
- Port 5 packet streaming, out_rdy dropped for 4 cycles mid-payload:
  - required: at most one word emitted after the drop;
  - required: no loss or duplication after resume.
- Port 1 fills while port 6 is granted and stalled:
  - required: in_rdy_1 = 0 at nearly-full;
  - required: port 1 is served only after port 6's last word.
- Reset asserted mid-payload on port 2:
  - required: out_wr = 0 the next cycle;
  - required: all in_rdy = 1;
  - required: a following packet on port 2 is output intact and alone.
- With INPUT_ARB_SRC_PORT_STAMP_EN, packet on port 6 whose header has source field 0xFFFF:
  - required: output header source field = 0x0006;
  - required: all other bits unchanged.
